// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: turn size, angle width and sweep FSM states.
package cordic_pkg;

  localparam int unsigned FULL_TURN_DEG = 360;
  localparam int unsigned ANGLE_W       = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/cordic_angle_wrap.sv
// Combinational modulo-FULL_TURN angle step: returns the next angle and
// flags when the step crossed the 0/FULL_TURN boundary.
module cordic_angle_wrap #(
  parameter int unsigned FULL_TURN = cordic_pkg::FULL_TURN_DEG
) (
  input  logic [15:0] angle,
  input  logic [15:0] step,
  input  logic        dir,
  output logic [15:0] next_angle,
  output logic        wrapped
);

  localparam logic [16:0] TURN = 17'(FULL_TURN);

  logic [16:0] a17;
  logic [16:0] s17;
  logic [16:0] sum;

  assign a17 = {1'b0, angle};
  assign s17 = {1'b0, step};

  always_comb begin
    sum        = a17 + s17;
    wrapped    = 1'b0;
    next_angle = '0;
    if (!dir) begin
      wrapped    = (sum >= TURN);
      next_angle = wrapped ? 16'(sum - TURN) : 16'(sum);
    end else begin
      wrapped    = (a17 < s17);
      next_angle = wrapped ? 16'(a17 + TURN - s17) : 16'(a17 - s17);
    end
  end

endmodule

// File: rtl/cordic_angle_sweep.sv
// Angle-sequence generator feeding cordic_rotate: emits start_deg, then steps
// of step_deg modulo FULL_TURN every `interval` clocks, single-turn or continuous.
module cordic_angle_sweep #(
  parameter int unsigned ANGLE_W   = cordic_pkg::ANGLE_W,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned FULL_TURN = cordic_pkg::FULL_TURN_DEG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               single,
  input  logic               dir,
  input  logic [15:0]        start_deg,
  input  logic [15:0]        step_deg,
  input  logic [DIV_W-1:0]   interval,
  output logic [ANGLE_W-1:0] angle,
  output logic               angle_valid,
  output logic               wrap,
  output logic               busy,
  output logic               sweep_done,
  output logic               cfg_err
);

  import cordic_pkg::*;

  localparam logic [16:0] TURN = 17'(FULL_TURN);

  sweep_state_t      state, state_next;
  logic              cfg_single, cfg_dir;
  logic [15:0]       cfg_step;
  logic [DIV_W-1:0]  cfg_interval;
  logic [DIV_W-1:0]  cnt;
  logic [15:0]       angle_q;
  logic [15:0]       next_angle;
  logic              next_wrapped;
  logic              cfg_ok, start_ok, start_bad, update, suppress;
  logic              valid_d, wrap_d, err_d;

  assign cfg_ok    = ({1'b0, start_deg} < TURN) && ({1'b0, step_deg} < TURN);
  assign start_ok  = (state == IDLE) && start && !stop && cfg_ok;
  assign start_bad = (state == IDLE) && start && !stop && !cfg_ok;
  // stop masks the update so an abort never produces a trailing strobe
  assign update    = (state == RUN) && !stop && (cnt == cfg_interval - DIV_W'(1));
  assign suppress  = cfg_single && next_wrapped;

  cordic_angle_wrap #(
    .FULL_TURN(FULL_TURN)
  ) u_wrap (
    .angle     (angle_q),
    .step      (cfg_step),
    .dir       (cfg_dir),
    .next_angle(next_angle),
    .wrapped   (next_wrapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN: begin
        if (stop)                     state_next = IDLE;
        else if (update && suppress)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    sweep_done = (state == DONE);
    valid_d    = start_ok || (update && !suppress);
    wrap_d     = update && next_wrapped && !cfg_single;
    err_d      = start_bad;
    angle      = ANGLE_W'(angle_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_single   <= 1'b0;
      cfg_dir      <= 1'b0;
      cfg_step     <= '0;
      cfg_interval <= '0;
      cnt          <= '0;
      angle_q      <= '0;
      angle_valid  <= 1'b0;
      wrap         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      angle_valid <= valid_d;
      wrap        <= wrap_d;
      cfg_err     <= err_d;
      if (start_ok) begin
        cfg_single   <= single;
        cfg_dir      <= dir;
        cfg_step     <= step_deg;
        cfg_interval <= (interval == '0) ? DIV_W'(1) : interval;
        angle_q      <= start_deg;
        cnt          <= '0;
      end else if (state == RUN && !stop) begin
        if (update) begin
          cnt <= '0;
          if (!suppress) angle_q <= next_angle;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_angle_sweep.sv
// Self-checking bench for cordic_angle_sweep against a modulo-arithmetic model.
module tb_cordic_angle_sweep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, single = 1'b0, dir = 1'b0;
  logic [15:0] start_deg = '0, step_deg = '0;
  logic [15:0] interval = '0;
  logic [31:0] angle;
  logic        angle_valid, wrap, busy, sweep_done, cfg_err;

  int errors = 0;
  int checks = 0;

  cordic_angle_sweep #(
    .ANGLE_W  (32),
    .DIV_W    (16),
    .FULL_TURN(360)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .single     (single),
    .dir        (dir),
    .start_deg  (start_deg),
    .step_deg   (step_deg),
    .interval   (interval),
    .angle      (angle),
    .angle_valid(angle_valid),
    .wrap       (wrap),
    .busy       (busy),
    .sweep_done (sweep_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: angles live on a circle of 360 degrees
  function automatic int model_next(input int a, input int st, input bit d, output bit w);
    int t;
    if (!d) begin
      t = a + st;
      w = (t >= 360);
      return t % 360;
    end
    t = a - st;
    w = (t < 0);
    return (t + 360) % 360;
  endfunction

  function automatic int single_count(input int s, input int st, input bit d);
    int x, n;
    bit w;
    x = s;
    n = 1;
    forever begin
      x = model_next(x, st, d, w);
      if (w) return n;
      n++;
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_angle"}, angle, 0);
    chk({tag, "_valid"}, angle_valid, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, sweep_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  // Called at a negedge with the DUT idle. Continuous sweeps check n strobes then stop.
  task automatic sweep(input string tag, input int s, input int st, input bit d,
                       input bit sg, input int iv, input int n_cont);
    int a, last, gap, got, since, n, c, bound, nx, extra;
    bit w_exp, w_nx;
    gap = (iv == 0) ? 1 : iv;
    n = sg ? single_count(s, st, d) : n_cont;
    bound = (n + 2) * gap + 20;
    a = s; last = s; w_exp = 1'b0; got = 0; since = 0; c = 0;
    start_deg = 16'(s); step_deg = 16'(st); dir = d; single = sg; interval = 16'(iv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (got < n && c < bound) begin
      if (angle_valid) begin
        chk({tag, "_angle"}, angle, a);
        chk({tag, "_wrap"}, wrap, w_exp);
        chk({tag, "_gap"}, since, (got == 0) ? 0 : gap);
        chk({tag, "_busy"}, busy, 1);
        got++;
        last = a;
        since = 0;
        nx = model_next(a, st, d, w_nx);
        a = nx;
        w_exp = w_nx;
      end else if (wrap) begin
        chk({tag, "_stray_wrap"}, wrap, 0);
      end
      if (got < n) begin
        since++;
        c++;
        @(negedge clk);
      end
    end
    chk({tag, "_count"}, got, n);
    if (sg) begin
      since = 0;
      extra = 0;
      do begin
        @(negedge clk);
        since++;
        if (angle_valid) extra++;
      end while (!sweep_done && since < gap + 5);
      chk({tag, "_done_gap"}, since, gap);
      chk({tag, "_extra_strobes"}, extra, 0);
      chk({tag, "_done_busy"}, busy, 0);
      chk({tag, "_hold"}, angle, last);
      @(negedge clk);
      chk({tag, "_done_pulse"}, sweep_done, 0);
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk({tag, "_stop_busy"}, busy, 0);
      chk({tag, "_stop_hold"}, angle, last);
      extra = 0;
      repeat (2 * gap + 2) begin
        if (angle_valid) extra++;
        @(negedge clk);
      end
      chk({tag, "_after_stop"}, extra, 0);
      chk({tag, "_after_stop_angle"}, angle, last);
    end
  endtask

  initial begin
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sweep("full_turn", 0, 1, 1'b0, 1'b1, 20, 0);
    sweep("cont_wrap", 350, 7, 1'b0, 1'b0, 1, 5);
    sweep("dec_cont", 5, 10, 1'b1, 1'b0, 2, 3);
    sweep("dec_single", 5, 10, 1'b1, 1'b1, 3, 0);
    sweep("stop_30", 0, 10, 1'b0, 1'b0, 4, 4);
    sweep("interval0", 0, 90, 1'b0, 1'b0, 0, 5);

    // start and stop together in IDLE: stop wins
    start_deg = 16'd77; step_deg = 16'd3; single = 1'b0; dir = 1'b0; interval = 16'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_valid", angle_valid, 0);
    chk("startstop_busy", busy, 0);
    chk("startstop_angle", angle, 0);
    @(negedge clk);
    chk("startstop_busy2", busy, 0);

    // step of a full turn is rejected
    start_deg = 16'd20; step_deg = 16'd360;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_step_err", cfg_err, 1);
    chk("bad_step_busy", busy, 0);
    chk("bad_step_valid", angle_valid, 0);
    chk("bad_step_angle", angle, 0);
    @(negedge clk);
    chk("bad_step_err_pulse", cfg_err, 0);
    chk("bad_step_idle", busy, 0);

    start_deg = 16'd360; step_deg = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_start_err", cfg_err, 1);
    chk("bad_start_busy", busy, 0);

    for (int k = 0; k < 4; k++)
      sweep("rand_cont", int'($urandom_range(359, 0)), int'($urandom_range(359, 0)),
            1'($urandom_range(1, 0)), 1'b0, int'($urandom_range(5, 0)), 6);
    for (int k = 0; k < 2; k++)
      sweep("rand_single", int'($urandom_range(359, 0)), int'($urandom_range(359, 25)),
            1'($urandom_range(1, 0)), 1'b1, int'($urandom_range(4, 0)), 0);

    // asynchronous reset while running, checked before the next clock edge
    start_deg = 16'd100; step_deg = 16'd1; single = 1'b0; dir = 1'b0; interval = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep("post_reset", 10, 45, 1'b0, 1'b1, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_angle_sweep.md
Name: cordic_angle_sweep

Overview:
Angle-sequence generator that sits directly upstream of cordic_rotate and drives its signed integer-degree angle input. On start it emits a configurable arithmetic sequence of angles, reduced modulo 360, at a programmable cycle interval. Each new angle is marked with a one-cycle valid strobe. It supports single-turn and continuous modes, either direction, and replaces hand-stepped angle sweeps in benches and the system datapath.

Parameters:
ANGLE_W, 32, width of angle output (signed, integer degrees, matches cordic_rotate angle)
DIV_W, 16, width of interval counter/config
FULL_TURN, 360, degrees per turn; modulo base

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a sweep (sampled in IDLE only)
stop  in  1  one-cycle request to abort a running sweep
single  in  1  1 = stop after one full turn, 0 = continuous
dir  in  1  0 = increasing angle, 1 = decreasing
start_deg  in  16  first angle, unsigned, must be < FULL_TURN
step_deg  in  16  angle increment, unsigned, must be < FULL_TURN
interval  in  DIV_W  clocks between successive angles; 0 treated as 1
angle  out  ANGLE_W  current angle, signed, always in [0, FULL_TURN-1]
angle_valid  out  1  one-cycle strobe: angle holds a new value
wrap  out  1  one-cycle strobe, coincident with angle_valid, when the sequence crossed 0/360
busy  out  1  high while in RUN
sweep_done  out  1  one-cycle strobe at end of a single-turn sweep
cfg_err  out  1  one-cycle strobe: start rejected due to bad config

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: angle=0; angle_valid, wrap, busy, sweep_done, cfg_err all 0; state IDLE; counters 0. Asserting rst mid-sweep clears everything immediately, without waiting for a clock edge.
- States: IDLE, RUN, DONE.
- IDLE, start=1, stop=0, start_deg<FULL_TURN, step_deg<FULL_TURN:
  - Latch single, dir, step_deg and interval (0 becomes 1).
  - Next cycle: state=RUN, angle=start_deg, angle_valid=1, busy=1, interval counter=0.
- IDLE, start=1 with a bad start_deg or step_deg: cfg_err=1 for one cycle; stay in IDLE; angle unchanged.
- IDLE, start and stop in the same cycle: stop wins; stay in IDLE; no strobe.
- RUN, counting: counter increments each cycle. When counter==interval-1, the counter clears and an update occurs, so successive angle_valid strobes are exactly interval cycles apart.
- RUN, update with dir=0:
  - s = angle+step.
  - If s >= FULL_TURN: new = s-FULL_TURN, and the update is a wrap.
- RUN, update with dir=1:
  - If angle < step: new = angle+FULL_TURN-step, and the update is a wrap.
  - Otherwise: new = angle-step.
- Update outcome:
  - Non-wrap: angle=new, angle_valid=1.
  - Wrap, continuous mode: angle=new, angle_valid=1, wrap=1.
  - Wrap, single mode: no strobe, angle holds, next state DONE.
- Single-mode result: a single sweep never re-emits an angle across the 0/360 boundary. For example, start 0, step 1 emits exactly 0..359.
- step_deg=0: the same angle is re-emitted every interval. In single mode this never terminates; only stop ends it.
- RUN, stop=1: next state IDLE, busy=0, angle holds its last value. Stop has priority over an update occurring in the same cycle: no strobe is issued.
- start in RUN or DONE: ignored. The latched configuration stays frozen for the whole sweep.
- DONE: sweep_done=1 and busy=0 for exactly one cycle, then IDLE.
- Arithmetic: internal sums use 17 bits unsigned, so there is no overflow. angle is zero-extended to ANGLE_W and is always non-negative.

Decomposition:
- Shared package cordic_pkg holds:
  - FULL_TURN_DEG=360
  - ANGLE_W
  - typedef enum sweep_state_t {IDLE, RUN, DONE}
  - These are shared with cordic_rotate and cordic_vector benches.
- One sub-module: cordic_angle_wrap, combinational.
  - Inputs: angle, step, dir.
  - Outputs: next_angle, wrapped.
  - Reused for the phase unwrap downstream of cordic_vector.

Test Plan:
- Full single-turn sweep: start_deg=0, step=1, interval=20, single=1, dir=0.
  - Exactly 360 angle_valid strobes, values 0..359, 20 cycles apart, wrap never high.
  - sweep_done 20 cycles after the strobe for 359 (one cycle after the suppressed wrap update); busy low in the same cycle.
- Continuous wrap: start_deg=350, step=7, interval=1, single=0.
  - Sequence 350, 357, 4 (wrap=1), 11, 18 on consecutive cycles.
- Decreasing direction: start_deg=5, step=10, dir=1.
  - Continuous mode: 5, 355 (wrap=1), 345.
  - Single mode: only 5 is emitted, then sweep_done.
- Stop and start priority:
  - Stop pulsed after angle=30 (start 0, step 10, interval 4): no further strobes, angle stays 30, busy=0 next cycle.
  - start+stop together in IDLE: no change.
- Configuration edge cases:
  - step_deg=360: cfg_err for one cycle, stays IDLE, angle unchanged.
  - interval=0, step=90: strobes 0, 90, 180, 270, 0 on consecutive cycles.
- Reset mid-sweep: assert rst between clock edges while in RUN.
  - All outputs are 0 before the next edge.
  - After release, start works normally.
